// File: rtl/videoram_scanout_if.sv
// Videoram read bus between the scanout engine and the 4096x32 videoram.
//   videoram_adrr : word address driven by the scanout (master)
//   videoram_data : read data from the RAM, valid one clock after the address
// master modport : scanout side; slave modport : RAM side.
interface videoram_scanout_if;
  logic [11:0] videoram_adrr;
  logic [31:0] videoram_data;

  modport master (output videoram_adrr, input videoram_data);
  modport slave  (input videoram_adrr, output videoram_data);
endinterface

// File: rtl/videoram_scanout.sv
// Read side of the videoram: 640x480@60 raster (default timing) with a 2x2 pixel
// scale, fetching 1 bpp 32-bit words (320x240 source, MSB leftmost) and driving
// RGB plus active-low syncs to the VGA DAC. Pixel tick every CLK_DIV clocks.
//
// Ports
//   clk          system clock
//   reset        synchronous, active-high
//   vram         videoram bus (master): address out, data in (1 clk latency)
//   marker_row   source row to highlight (only with SCANOUT_MARKER_EN)
//   vga_r/g/b    pixel colour, 0 outside the active area
//   vga_hs/vs    syncs, active low
//   vga_de       active-video flag
//   frame_start  1-clk pulse on the tick where the outputs show pixel (0,0)
//
// Optional feature macro: SCANOUT_MARKER_EN
//   When defined, 0-bits of source row marker_row are drawn red (scan-row
//   marker); marker_row is captured at frame start, values >= 240 disable it.
module videoram_scanout #(
  parameter int          CLK_DIV   = 2,
  parameter int          H_ACTIVE  = 640,
  parameter int          H_FP      = 16,
  parameter int          H_SYNC    = 96,
  parameter int          H_BP      = 48,
  parameter int          V_ACTIVE  = 480,
  parameter int          V_FP      = 10,
  parameter int          V_SYNC    = 2,
  parameter int          V_BP      = 33,
  parameter logic [11:0] BASE_ADDR = 12'h000,
  parameter logic [23:0] FG_COLOR  = 24'hFFFFFF,
  parameter logic [23:0] BG_COLOR  = 24'h000000
) (
  input  logic               clk,
  input  logic               reset,
  videoram_scanout_if.master vram,
`ifdef SCANOUT_MARKER_EN
  input  logic [7:0]         marker_row,
`endif
  output logic [7:0]         vga_r,
  output logic [7:0]         vga_g,
  output logic [7:0]         vga_b,
  output logic               vga_hs,
  output logic               vga_vs,
  output logic               vga_de,
  output logic               frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int H_W     = $clog2(H_TOTAL);
  localparam int V_W     = $clog2(V_TOTAL);
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int WPL     = H_ACTIVE / 64;   // source words per line
  localparam int IDX_W   = H_W - 6;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [H_W-1:0]   H_ACT    = H_W'(H_ACTIVE);
  localparam logic [H_W-1:0]   H_PREF   = H_W'(H_TOTAL - 8);
  localparam logic [H_W-1:0]   H_LAST   = H_W'(H_TOTAL - 1);
  localparam logic [H_W-1:0]   HS_BEG   = H_W'(H_ACTIVE + H_FP);
  localparam logic [H_W-1:0]   HS_END   = H_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [V_W-1:0]   V_ACT    = V_W'(V_ACTIVE);
  localparam logic [V_W-1:0]   V_LAST   = V_W'(V_TOTAL - 1);
  localparam logic [V_W-1:0]   VS_BEG   = V_W'(V_ACTIVE + V_FP);
  localparam logic [V_W-1:0]   VS_END   = V_W'(V_ACTIVE + V_FP + V_SYNC);

  // Word address of word idx on the given display line (two display lines per source line).
  function automatic logic [11:0] word_addr(input logic [V_W-1:0] line, input logic [11:0] idx);
    logic [11:0] sy;
    sy = 12'(line >> 1);
    return BASE_ADDR + sy * 12'(WPL) + idx;
  endfunction

  logic [DIV_W-1:0] r_div;
  logic [H_W-1:0]   r_h;
  logic [V_W-1:0]   r_v;
  logic [31:0]      r_cur_word;
  logic [31:0]      r_next_word;
  logic [11:0]      r_adrr;
  logic             r_rd_vld_p0;
  logic             r_rd_vld_p1;
  logic [23:0]      r_rgb;
  logic             r_hs;
  logic             r_vs;
  logic             r_de;
  logic             r_frame_start;

  logic             w_tick;
  logic             w_h_last;
  logic             w_v_last;
  logic [V_W-1:0]   w_v_next;
  logic             w_coming_act;
  logic             w_cur_act;
  logic             w_word_end;
  logic [IDX_W-1:0] w_widx;
  logic             w_more_words;
  logic             w_iss_w0;
  logic             w_iss_w1;
  logic             w_iss_nx;
  logic             w_issue;
  logic [11:0]      w_issue_addr;
  logic             w_bit;
  logic             w_de;
  logic             w_hs_n;
  logic             w_vs_n;
  logic             w_frame_tick;
  logic [23:0]      w_rgb;

  assign w_tick       = (r_div == DIV_LAST);
  assign w_h_last     = (r_h == H_LAST);
  assign w_v_last     = (r_v == V_LAST);
  assign w_v_next     = w_v_last ? '0 : r_v + 1'b1;
  // Prefetch decisions at the end of a line concern the line about to start.
  assign w_coming_act = (w_v_next < V_ACT);
  assign w_cur_act    = (r_v < V_ACT);
  // Last display pixel of a source word: sx[4:0]==31 and h[0]==1.
  assign w_word_end   = (r_h[5:0] == 6'h3F) && (r_h < H_ACT);
  assign w_widx       = r_h[H_W-1:6];
  assign w_more_words = (32'(w_widx) + 32'd2) < 32'(WPL);

  assign w_iss_w0     = w_tick && (r_h == H_PREF) && w_coming_act;
  assign w_iss_w1     = w_tick && w_h_last && w_coming_act && (WPL > 1);
  assign w_iss_nx     = w_tick && w_word_end && w_cur_act && w_more_words;
  assign w_issue      = w_iss_w0 || w_iss_w1 || w_iss_nx;

  always_comb begin
    w_issue_addr = r_adrr;
    if (w_iss_w0)      w_issue_addr = word_addr(w_v_next, 12'd0);
    else if (w_iss_w1) w_issue_addr = word_addr(w_v_next, 12'd1);
    else if (w_iss_nx) w_issue_addr = word_addr(r_v, 12'(w_widx) + 12'd2);
  end

  // Bit 31 is the leftmost pixel, so the bit index is ~sx[4:0].
  assign w_bit        = r_cur_word[~r_h[5:1]];
  assign w_de         = (r_h < H_ACT) && (r_v < V_ACT);
  assign w_hs_n       = !((r_h >= HS_BEG) && (r_h < HS_END));
  assign w_vs_n       = !((r_v >= VS_BEG) && (r_v < VS_END));
  assign w_frame_tick = w_tick && (r_h == '0) && (r_v == '0);

`ifdef SCANOUT_MARKER_EN
  localparam logic [23:0] MARK_COLOR = 24'hFF0000;

  logic [7:0] r_marker_row;
  logic [7:0] w_mrow;
  logic       w_mark_hit;

  // Pixel (0,0) is rendered on the same tick the new row is captured, so it
  // sees the incoming value directly.
  assign w_mrow     = w_frame_tick ? marker_row : r_marker_row;
  assign w_mark_hit = (w_mrow < 8'd240) && (9'(r_v >> 1) == {1'b0, w_mrow});

  always_ff @(posedge clk) begin
    if (reset)             r_marker_row <= 8'hFF;
    else if (w_frame_tick) r_marker_row <= marker_row;
  end
`endif

  always_comb begin
    w_rgb = 24'h000000;
    if (w_de) begin
      if (w_bit)           w_rgb = FG_COLOR;
`ifdef SCANOUT_MARKER_EN
      else if (w_mark_hit) w_rgb = MARK_COLOR;
`endif
      else                 w_rgb = BG_COLOR;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_div         <= '0;
      r_h           <= H_ACT;
      r_v           <= V_LAST;
      r_cur_word    <= 32'h0;
      r_next_word   <= 32'h0;
      r_adrr        <= BASE_ADDR;
      r_rd_vld_p0   <= 1'b0;
      r_rd_vld_p1   <= 1'b0;
      r_rgb         <= 24'h000000;
      r_hs          <= 1'b1;
      r_vs          <= 1'b1;
      r_de          <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_div         <= w_tick ? '0 : r_div + 1'b1;
      r_frame_start <= 1'b0;

      // Tick stage: outputs take the current counter state, counters advance.
      if (w_tick) begin
        r_rgb         <= w_rgb;
        r_hs          <= w_hs_n;
        r_vs          <= w_vs_n;
        r_de          <= w_de;
        r_frame_start <= w_frame_tick;
        if (w_h_last || w_word_end) r_cur_word <= r_next_word;
        if (w_h_last) begin
          r_h <= '0;
          r_v <= w_v_next;
        end else begin
          r_h <= r_h + 1'b1;
        end
      end

      // Fetch stage: address issued (p0), RAM latches it (p1), data captured.
      if (w_issue) r_adrr <= w_issue_addr;
      r_rd_vld_p0 <= w_issue;
      r_rd_vld_p1 <= r_rd_vld_p0;
      if (r_rd_vld_p1) r_next_word <= vram.videoram_data;
    end
  end

  assign vram.videoram_adrr = r_adrr;
  assign vga_r              = r_rgb[23:16];
  assign vga_g              = r_rgb[15:8];
  assign vga_b              = r_rgb[7:0];
  assign vga_hs             = r_hs;
  assign vga_vs             = r_vs;
  assign vga_de             = r_de;
  assign frame_start        = r_frame_start;

endmodule

// File: tb/tb_videoram_scanout.sv
// Bench for videoram_scanout with a reduced raster so several frames fit in a
// short run. The reference model derives every output from the raster position
// (tick count since reset) and the RAM contents using plain arithmetic.
module tb_videoram_scanout;
  localparam int CLK_DIV  = 2;
  localparam int H_ACTIVE = 256;
  localparam int H_FP     = 4;
  localparam int H_SYNC   = 8;
  localparam int H_BP     = 12;
  localparam int V_ACTIVE = 16;
  localparam int V_FP     = 2;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 4;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int FRAME    = H_TOTAL * V_TOTAL;
  localparam int PERIOD   = FRAME * CLK_DIV;
  localparam int WPL      = H_ACTIVE / 64;
  localparam int P0       = (V_TOTAL - 1) * H_TOTAL + H_ACTIVE;  // raster position after reset
  localparam int FIRST_FS = (H_TOTAL - H_ACTIVE) * CLK_DIV + CLK_DIV;
  localparam int TARGET   = 10 * H_TOTAL + 100;
  localparam logic [11:0] BASE = 12'hFF0;
  localparam logic [23:0] FG   = 24'h00FF80;
  localparam logic [23:0] BG   = 24'h102030;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  videoram_scanout_if vif();
  logic [7:0] r, g, b;
  logic       hs, vs, de, fs;
`ifdef SCANOUT_MARKER_EN
  logic [7:0] marker_row;
`endif

  logic [31:0] mem [4096];
  always @(posedge clk) vif.videoram_data <= mem[vif.videoram_adrr];

  videoram_scanout #(
    .CLK_DIV(CLK_DIV), .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .BASE_ADDR(BASE), .FG_COLOR(FG), .BG_COLOR(BG)
  ) dut (
    .clk(clk),
    .reset(rst),
    .vram(vif),
`ifdef SCANOUT_MARKER_EN
    .marker_row(marker_row),
`endif
    .vga_r(r), .vga_g(g), .vga_b(b),
    .vga_hs(hs), .vga_vs(vs), .vga_de(de),
    .frame_start(fs)
  );

  int          n_vec = 0;
  int          n_bad = 0;
  int          clk_cnt, tick_cnt, pos;
  bit          shown, fs_exp;
  logic [11:0] exp_adr;
  logic [7:0]  mk_s;
  int          fs_seen, fs_last, cnt_de, cnt_hs, cnt_vs;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  function automatic logic [11:0] addr_of(input int v, input int widx);
    return 12'((int'(BASE) + (v / 2) * WPL + widx) % 4096);
  endfunction

  // Expected {rgb, hs, vs, de, frame_start} for the current model state.
  function automatic logic [28:0] model_out();
    int h, v;
    logic [31:0] w;
    logic [23:0] rgb;
    logic ehs, evs, ede, bitv;
    if (!shown) return {24'h0, 1'b1, 1'b1, 1'b0, 1'b0};
    h   = pos % H_TOTAL;
    v   = pos / H_TOTAL;
    ede = (h < H_ACTIVE) && (v < V_ACTIVE);
    ehs = !((h >= H_ACTIVE + H_FP) && (h < H_ACTIVE + H_FP + H_SYNC));
    evs = !((v >= V_ACTIVE + V_FP) && (v < V_ACTIVE + V_FP + V_SYNC));
    rgb = 24'h0;
    if (ede) begin
      w    = mem[addr_of(v, h / 64)];
      bitv = w[31 - ((h / 2) % 32)];
      rgb  = bitv ? FG : BG;
`ifdef SCANOUT_MARKER_EN
      if (!bitv && (v / 2) == int'(mk_s) && mk_s < 8'd240) rgb = 24'hFF0000;
`endif
    end
    return {rgb, ehs, evs, ede, fs_exp};
  endfunction

  // Fetch schedule: word 0 at h=H_TOTAL-8, word 1 at h=H_TOTAL-1 (coming line),
  // word k+2 at the last pixel of word k.
  task automatic model_addr();
    int h, v, nl;
    h  = pos % H_TOTAL;
    v  = pos / H_TOTAL;
    nl = (v + 1) % V_TOTAL;
    if (h == H_TOTAL - 8 && nl < V_ACTIVE) exp_adr = addr_of(nl, 0);
    if (h == H_TOTAL - 1 && nl < V_ACTIVE) exp_adr = addr_of(nl, 1);
    if (v < V_ACTIVE && h < H_ACTIVE && (h % 64) == 63 && (h / 64 + 2) < WPL)
      exp_adr = addr_of(v, h / 64 + 2);
  endtask

  task automatic step();
    bit rs;
    logic [7:0] mk_now;
    rs = rst;
    mk_now = 8'hFF;
`ifdef SCANOUT_MARKER_EN
    mk_now = marker_row;
`endif
    @(posedge clk);
    #1;
    if (rs) begin
      clk_cnt = 0; tick_cnt = 0; shown = 0; pos = 0; fs_exp = 0;
      exp_adr = BASE; mk_s = 8'hFF;
      fs_seen = 0; fs_last = 0; cnt_de = 0; cnt_hs = 0; cnt_vs = 0;
    end else begin
      clk_cnt++;
      fs_exp = 0;
      if (clk_cnt % CLK_DIV == 0) begin
        tick_cnt++;
        shown = 1;
        pos = (P0 + tick_cnt - 1) % FRAME;
        if (pos == 0) begin
          fs_exp = 1;
          mk_s = mk_now;
        end
        model_addr();
      end
    end
    check_eq("video", {r, g, b, hs, vs, de, fs}, model_out());
    check_eq("adrr", vif.videoram_adrr, exp_adr);
    if (!rs && fs === 1'b1) begin
      if (fs_seen == 0) begin
        check_eq("fs_first", clk_cnt, FIRST_FS);
      end else begin
        check_eq("fs_period", clk_cnt - fs_last, PERIOD);
        check_eq("de_clks", cnt_de, H_ACTIVE * V_ACTIVE * CLK_DIV);
        check_eq("hs_clks", cnt_hs, H_SYNC * CLK_DIV * V_TOTAL);
        check_eq("vs_clks", cnt_vs, V_SYNC * H_TOTAL * CLK_DIV);
      end
      fs_seen++;
      fs_last = clk_cnt;
      cnt_de = 0; cnt_hs = 0; cnt_vs = 0;
    end
    cnt_de += (de === 1'b1) ? 1 : 0;
    cnt_hs += (hs === 1'b0) ? 1 : 0;
    cnt_vs += (vs === 1'b0) ? 1 : 0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
`ifdef SCANOUT_MARKER_EN
      if (i % 5000 == 2500) marker_row = 8'($urandom_range(0, 9));
`endif
      step();
    end
  endtask

  function automatic int fs_expected(input int clks);
    return (clks >= FIRST_FS) ? 1 + (clks - FIRST_FS) / PERIOD : 0;
  endfunction

  initial begin
    rst = 1'b1;
`ifdef SCANOUT_MARKER_EN
    marker_row = 8'd3;
`endif
    // Phase 1: only word (0,0) set -> first 64 display pixels of lines 0,1 are FG.
    for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
    mem[BASE] = 32'hFFFFFFFF;
    repeat (3) step();
    rst = 1'b0;
    run(2 * PERIOD + 200);
    check_eq("fs_count1", fs_seen, fs_expected(clk_cnt));

    // Phase 2: random RAM, then a one-clock reset in the middle of the frame.
    rst = 1'b1;
    for (int i = 0; i < 4096; i++) mem[i] = $urandom();
    repeat (2) step();
    rst = 1'b0;
    begin
      int k;
      k = 0;
      while (!(shown && pos == TARGET && fs_seen > 0) && k < 2 * PERIOD) begin
        step();
        k++;
      end
      check_eq("reach_mid", {31'd0, (shown && pos == TARGET)}, 32'd1);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    run(PERIOD + FIRST_FS + 200);
    check_eq("fs_count2", fs_seen, fs_expected(clk_cnt));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
